ise_image_feeder: RTL and testbench



---
 rtl/ise_image_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_ise_image_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ise_image_feeder.sv
// ise_image_feeder
//
// Purpose: streams NUM_IMAGES images of PIX_PER_IMG pixels each from a pixel
// memory into a sorting engine. The engine signals between images with a
// busy high/low pulse. The feeder then collects the engine's ranked results
// into a result store.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle pulse, starts a run from IDLE or DONE
//   mem_re, mem_addr  pixel memory read; mem_addr = {image[4:0], pixel[13:0]}
//   mem_rdata         read data {R,G,B}, valid the cycle after mem_re
//   busy              engine busy; stalls pixel transfers
//   pixel_in, image_in_index, pix_vld   pixel presented to the engine
//   out_valid, color_index, image_out_index   engine result strobe and data
//   res_we, res_addr, res_data          result store write port
//   done              run complete, held until next start or reset
module ise_image_feeder #(
    parameter int NUM_IMAGES  = 32,
    parameter int PIX_PER_IMG = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_re,
    output logic [18:0] mem_addr,
    input  logic [23:0] mem_rdata,
    input  logic        busy,
    output logic [23:0] pixel_in,
    output logic [4:0]  image_in_index,
    output logic        pix_vld,
    input  logic        out_valid,
    input  logic [1:0]  color_index,
    input  logic [4:0]  image_out_index,
    output logic        res_we,
    output logic [4:0]  res_addr,
    output logic [6:0]  res_data,
    output logic        done
);

    localparam logic [13:0] LAST_PIX = 14'(PIX_PER_IMG - 1);
    localparam logic [4:0]  LAST_IMG = 5'(NUM_IMAGES - 1);
    localparam logic [5:0]  N_IMG    = 6'(NUM_IMAGES);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_COLLECT, S_DONE
    } state_t;

    state_t      state_q;

    // Read side: address of the next word to fetch from pixel memory.
    logic [4:0]  rd_img_q;
    logic [13:0] rd_pix_q;
    logic        rd_end_q;      // last address of the run already issued
    logic        inflight_q;    // a read was issued last cycle, data arrives now

    // Output register plus one-entry skid buffer.
    logic        out_full_q;
    logic [23:0] out_data_q;
    logic        skid_full_q;
    logic [23:0] skid_data_q;

    // Transfer side: image/pixel of the word currently presented.
    logic [5:0]  img_q;         // one bit wider so NUM_IMAGES=32 is representable
    logic [13:0] pix_q;

    // Result side.
    logic [5:0]  res_cnt_q;
    logic        res_we_q;
    logic [4:0]  res_addr_q;
    logic [6:0]  res_data_q;
    logic        done_q;

    logic        in_wait;
    logic        xfer;
    logic        rd_ok;
    logic [2:0]  occ_next;

    assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign pix_vld = out_full_q && (state_q == S_SEND);
    assign xfer    = pix_vld && !busy;

    // Words held after this edge, not counting a read issued now. A new read
    // is allowed only if its data will find a free slot one cycle later.
    assign occ_next = 3'(out_full_q) + 3'(skid_full_q) + 3'(inflight_q) - 3'(xfer);

    // While sending, only addresses of the image being sent are fetched, so
    // nothing of the next image is queued behind its last pixel. Between
    // images only the next image's first pixel may be prefetched.
    assign rd_ok  = !rd_end_q && ({1'b0, rd_img_q} == img_q)
                    && ((state_q == S_SEND) || (in_wait && (rd_pix_q == 14'd0)));
    assign mem_re = rd_ok && (occ_next < 3'd2);

    assign mem_addr       = {rd_img_q, rd_pix_q};
    assign pixel_in       = out_data_q;
    assign image_in_index = img_q[4:0];
    assign res_we         = res_we_q;
    assign res_addr       = res_addr_q;
    assign res_data       = res_data_q;
    assign done           = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_img_q    <= '0;
            rd_pix_q    <= '0;
            rd_end_q    <= 1'b0;
            inflight_q  <= 1'b0;
            out_full_q  <= 1'b0;
            out_data_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            img_q       <= '0;
            pix_q       <= '0;
            res_cnt_q   <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            // Result capture runs alongside pixel flow in every active state.
            res_we_q <= 1'b0;
            if (out_valid && (state_q != S_IDLE) && (state_q != S_DONE)
                && (res_cnt_q < N_IMG)) begin
                res_we_q   <= 1'b1;
                res_addr_q <= res_cnt_q[4:0];
                res_data_q <= {color_index, image_out_index};
                res_cnt_q  <= res_cnt_q + 6'd1;
            end

            // Read address advance.
            inflight_q <= mem_re;
            if (mem_re) begin
                if (rd_pix_q == LAST_PIX) begin
                    rd_pix_q <= '0;
                    if (rd_img_q == LAST_IMG) rd_end_q <= 1'b1;
                    else                      rd_img_q <= rd_img_q + 5'd1;
                end else begin
                    rd_pix_q <= rd_pix_q + 14'd1;
                end
            end

            // Output register refills from the skid buffer first, so the
            // older word always leaves first.
            if (!out_full_q || xfer) begin
                if (skid_full_q) begin
                    out_data_q  <= skid_data_q;
                    out_full_q  <= 1'b1;
                    skid_full_q <= inflight_q;
                    skid_data_q <= mem_rdata;
                end else if (inflight_q) begin
                    out_data_q <= mem_rdata;
                    out_full_q <= 1'b1;
                end else begin
                    out_full_q <= 1'b0;
                end
            end else if (inflight_q) begin
                skid_data_q <= mem_rdata;
                skid_full_q <= 1'b1;
            end

            // Transfer counters.
            if (xfer) begin
                if (pix_q == LAST_PIX) begin
                    pix_q <= '0;
                    img_q <= img_q + 6'd1;
                end else begin
                    pix_q <= pix_q + 14'd1;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_SEND;
                        rd_img_q    <= '0;
                        rd_pix_q    <= '0;
                        rd_end_q    <= 1'b0;
                        out_full_q  <= 1'b0;
                        skid_full_q <= 1'b0;
                        img_q       <= '0;
                        pix_q       <= '0;
                        res_cnt_q   <= '0;
                        done_q      <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (xfer && (pix_q == LAST_PIX)) state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (busy) state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // img_q has already advanced past the finished image.
                    if (!busy) state_q <= (img_q == N_IMG) ? S_COLLECT : S_SEND;
                end
                S_COLLECT: begin
                    if (res_cnt_q == N_IMG) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_image_feeder.sv
module tb_ise_image_feeder;

    localparam int NI = 2;
    localparam int PP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_re;
    logic [18:0] mem_addr;
    logic [23:0] mem_rdata;
    logic        busy;
    logic [23:0] pixel_in;
    logic [4:0]  image_in_index;
    logic        pix_vld;
    logic        out_valid;
    logic [1:0]  color_index;
    logic [4:0]  image_out_index;
    logic        res_we;
    logic [4:0]  res_addr;
    logic [6:0]  res_data;
    logic        done;

    ise_image_feeder #(.NUM_IMAGES(NI), .PIX_PER_IMG(PP)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .pixel_in(pixel_in), .image_in_index(image_in_index),
        .pix_vld(pix_vld), .out_valid(out_valid), .color_index(color_index),
        .image_out_index(image_out_index), .res_we(res_we), .res_addr(res_addr),
        .res_data(res_data), .done(done)
    );

    always #5 clk = ~clk;

    // Pixel memory: byte = addr[7:0] ^ {addr[17:14],4'b0}, replicated to R,G,B.
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= {3{mem_addr[7:0] ^ {mem_addr[17:14], 4'b0000}}};
    end

    typedef struct packed {
        logic [23:0] pix;
        logic [4:0]  img;
    } pix_t;

    pix_t        exp_pix[$];
    logic [18:0] exp_addr[$];
    logic [11:0] exp_res[$];   // {res_addr, res_data}

    int errors = 0;
    int checks = 0;
    int xfer_total = 0;
    logic        held_valid = 1'b0;
    logic [23:0] held_pix = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_re"},   32'(mem_re), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_pix_vld"},  32'(pix_vld), 0);
        chk({tag, "_pixel_in"}, 32'(pixel_in), 0);
        chk({tag, "_img_idx"},  32'(image_in_index), 0);
        chk({tag, "_res_we"},   32'(res_we), 0);
        chk({tag, "_res_addr"}, 32'(res_addr), 0);
        chk({tag, "_res_data"}, 32'(res_data), 0);
        chk({tag, "_done"},     32'(done), 0);
    endtask

    // Monitor: sample between edges, compare whatever the DUT presents.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_re) begin
                if (exp_addr.size() == 0) chk("extra_read", 32'(mem_re), 0);
                else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (held_valid && pix_vld) chk("stall_hold", 32'(pixel_in), 32'(held_pix));
            held_valid = pix_vld && busy;
            held_pix   = pixel_in;
            if (pix_vld && !busy) begin
                pix_t e;
                xfer_total++;
                $display("xfer img=%0d pixel=%06h", image_in_index, pixel_in);
                if (exp_pix.size() == 0) chk("extra_pixel", 32'(pix_vld), 0);
                else begin
                    e = exp_pix.pop_front();
                    chk("pixel_in", 32'(pixel_in), 32'(e.pix));
                    chk("image_in_index", 32'(image_in_index), 32'(e.img));
                end
            end
            if (res_we) begin
                $display("result addr=%0d data=%07b", res_addr, res_data);
                if (exp_res.size() == 0) chk("extra_res_we", 32'(res_we), 0);
                else chk("result", 32'({res_addr, res_data}), 32'(exp_res.pop_front()));
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_total < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("xfer_timeout", 32'(xfer_total >= target), 1);
    endtask

    task automatic push_run();
        for (int im = 0; im < NI; im++) begin
            for (int p = 0; p < PP; p++) begin
                logic [7:0] b;
                b = 8'(p) ^ 8'(im << 4);
                exp_pix.push_back({{b, b, b}, 5'(im)});
                exp_addr.push_back({5'(im), 14'(p)});
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("done_cleared", 32'(done), 0);
    endtask

    task automatic do_run(input bit stall, input bit extra_res);
        int base;
        base = xfer_total;
        push_run();
        exp_res.push_back({5'd0, 7'b1000111});
        exp_res.push_back({5'd1, 7'b0000011});
        start_pulse();
        wait_xfers(base + 1);
        if (stall) begin
            #1 busy = 1'b1;
            repeat (3) @(posedge clk);
            #1 busy = 1'b0;
        end
        wait_xfers(base + 2);
        // Result strobe coinciding with a transfer, plus an ignored start.
        #1 out_valid = 1'b1; color_index = 2'd2; image_out_index = 5'd7; start = 1'b1;
        @(posedge clk); #1 out_valid = 1'b0; start = 1'b0;
        wait_xfers(base + 4);
        #1 busy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("wait_pix_vld", 32'(pix_vld), 0);
        end
        @(posedge clk); #1 busy = 1'b0;
        wait_xfers(base + 8);
        #1 busy = 1'b1;
        @(posedge clk); #1 busy = 1'b0;
        @(posedge clk); #1 out_valid = 1'b1; color_index = 2'd0; image_out_index = 5'd3;
        @(posedge clk); #1;
        if (extra_res) begin
            color_index = 2'd1; image_out_index = 5'd5;
            @(posedge clk); #1;
        end
        out_valid = 1'b0;
        begin
            int n = 0;
            while (!done && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("done", 32'(done), 1);
        repeat (2) @(negedge clk);
        chk("pix_left", 32'(exp_pix.size()), 0);
        chk("addr_left", 32'(exp_addr.size()), 0);
        chk("res_left", 32'(exp_res.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; busy = 1'b0; out_valid = 1'b0;
        color_index = '0; image_out_index = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_zero("idle");
        end

        do_run(1'b1, 1'b0);

        // Restart from DONE, then reset while pixel 2 of image 0 is presented.
        push_run();
        begin
            int base;
            base = xfer_total;
            start_pulse();
            wait_xfers(base + 2);
        end
        #2 reset = 1'b1;
        #1 check_zero("midrst");
        exp_pix.delete();
        exp_addr.delete();
        exp_res.delete();
        @(posedge clk); #1 reset = 1'b0;

        do_run(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
